// File: rtl/mlp_seq_regressor_pkg.sv
// mlp_pkg: shared types and helpers for the sequential MLP regressor.
//   state_t  - controller states (IDLE, L0 hidden layer, L1 output layer, DONE)
//   cnt_w    - counter width for an index range of n values (at least 1 bit)
//   imax     - integer max, used to size the shared MAC datapath
//   relu     - ReLU with either clamp-to-max or truncate-to-low-bits behaviour
package mlp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L0   = 2'd1,
        L1   = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Negative -> 0. Otherwise either clamp to 2^w-1 (sat) or keep the low w bits.
    // Callers sign-extend their accumulator to 64 bits and cast the result back down.
    function automatic logic [63:0] relu(input logic signed [63:0] v, input int w, input bit sat);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if (v < 0)
            return '0;
        if (sat && (v > $signed(mask)))
            return mask;
        return v & mask;
    endfunction

endpackage

// File: rtl/mlp_seq_regressor_if.sv
// mlp_seq_regressor_if: feature-in / result-out valid-ready bundle.
//   in_valid/in_ready/in_data    - feature vector, feature i at [i*IN_W +: IN_W]
//   out_valid/out_ready/out_data - ReLU'd regression value (OUT_W-1 bits, unsigned)
//   slave  modport: the regressor
//   master modport: whoever feeds features and consumes results
interface mlp_seq_regressor_if #(
    parameter int N_IN  = 21,
    parameter int IN_W  = 4,
    parameter int OUT_W = 22
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [N_IN*IN_W-1:0]   in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-2:0]       out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mlp_seq_regressor_mac.sv
// mlp_mac: single signed multiply-accumulate.
//   a       - unsigned operand (feature or hidden activation), zero-extended
//   w       - signed weight
//   acc_in  - running sum
//   acc_out - acc_in + a*w, two's-complement wrap at ACC_W
module mlp_mac #(
    parameter int A_W   = 13,
    parameter int W_W   = 8,
    parameter int ACC_W = 22
) (
    input  logic        [A_W-1:0]   a,
    input  logic signed [W_W-1:0]   w,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [ACC_W-1:0] acc_out
);
    // Extra bit keeps the zero-extended operand positive under signed multiply.
    localparam int P_W = A_W + W_W + 1;

    logic signed [P_W-1:0] prod;

    assign prod    = P_W'($signed({1'b0, a})) * P_W'(w);
    assign acc_out = acc_in + ACC_W'(prod);
endmodule

// File: rtl/mlp_seq_regressor.sv
// mlp_seq_regressor: 2-layer MLP regressor (ReLU hidden, ReLU output) evaluated
// serially on one shared MAC. Coefficients are parameters, selected by constant
// tables indexed with the (neuron, feature) / hidden counters.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mlp_seq_regressor_if.slave (feature input and result output handshakes)
// Accept edge to out_valid high takes N_HID*N_IN + N_HID + 1 cycles regardless of data.
module mlp_seq_regressor
    import mlp_pkg::*;
#(
    parameter int N_IN     = 21,
    parameter int IN_W     = 4,
    parameter int N_HID    = 3,
    parameter int W_W      = 8,
    parameter int B1_W     = 12,
    parameter int ACC_W    = 14,
    parameter int HID_W    = 13,
    parameter int B2_W     = 17,
    parameter int OUT_W    = 22,
    parameter bit RELU_SAT = 1'b0,
    parameter logic [N_HID*N_IN*W_W-1:0] W1 = '0,
    parameter logic [N_HID*B1_W-1:0]     B1 = '0,
    parameter logic [N_HID*W_W-1:0]      W2 = '0,
    parameter logic signed [B2_W-1:0]    B2 = '0
) (
    input  logic                clk,
    input  logic                rst,
    mlp_seq_regressor_if.slave  bus
);
    // One accumulator serves both layers; it is as wide as the wider of the two
    // and each layer only interprets its own low bits, so wrap behaviour matches.
    localparam int A_W   = imax(IN_W, HID_W);
    localparam int MAC_W = imax(ACC_W, OUT_W);
    localparam int I_W   = cnt_w(N_IN);
    localparam int J_W   = cnt_w(N_HID);
    localparam int WI_W  = cnt_w(N_HID * N_IN);
    localparam int OD_W  = OUT_W - 1;

    localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(N_HID - 1);

    // Coefficient tables: constants only, so indexing them is a plain mux.
    logic signed [W_W-1:0]  w1_tab [N_HID*N_IN];
    logic signed [B1_W-1:0] b1_tab [N_HID];
    logic signed [W_W-1:0]  w2_tab [N_HID];

    for (genvar g = 0; g < N_HID*N_IN; g++) begin : g_w1
        assign w1_tab[g] = W1[g*W_W +: W_W];
    end
    for (genvar g = 0; g < N_HID; g++) begin : g_l2
        assign b1_tab[g] = B1[g*B1_W +: B1_W];
        assign w2_tab[g] = W2[g*W_W +: W_W];
    end

    state_t                 state, state_nx;
    logic [I_W-1:0]         i;      // feature index in L0
    logic [J_W-1:0]         j;      // neuron index in L0, hidden index (k) in L1
    logic [IN_W-1:0]        x_q [N_IN];
    logic [HID_W-1:0]       h_q [N_HID];
    logic signed [MAC_W-1:0] acc;
    logic signed [MAC_W-1:0] mac_sum;
    logic [A_W-1:0]         mac_a;
    logic signed [W_W-1:0]  mac_w;
    logic [WI_W-1:0]        w1_idx;
    logic signed [ACC_W-1:0] hid_sum;
    logic signed [OUT_W-1:0] out_sum;
    logic [HID_W-1:0]       hid_act;
    logic [OD_W-1:0]        out_act;
    logic [OD_W-1:0]        out_q;
    logic                   out_valid_q;

    assign w1_idx = WI_W'(int'(j) * N_IN + int'(i));

    // Operand mux: features x weights in L0, hidden activations x output weights in L1.
    always_comb begin
        mac_a = '0;
        mac_w = '0;
        if (state == L1) begin
            mac_a = A_W'(h_q[j]);
            mac_w = w2_tab[j];
        end else begin
            mac_a = A_W'(x_q[i]);
            mac_w = w1_tab[w1_idx];
        end
    end

    mlp_mac #(
        .A_W   (A_W),
        .W_W   (W_W),
        .ACC_W (MAC_W)
    ) u_mac (
        .a       (mac_a),
        .w       (mac_w),
        .acc_in  (acc),
        .acc_out (mac_sum)
    );

    assign hid_sum = mac_sum[ACC_W-1:0];
    assign out_sum = mac_sum[OUT_W-1:0];
    assign hid_act = HID_W'(relu(64'(hid_sum), HID_W, RELU_SAT));
    assign out_act = OD_W'(relu(64'(out_sum), OD_W, RELU_SAT));

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)                  state_nx = L0;
            L0:      if (i == I_LAST && j == J_LAST)    state_nx = L1;
            L1:      if (j == J_LAST)                   state_nx = DONE;
            DONE:    if (out_valid_q && bus.out_ready)  state_nx = IDLE;
            default:                                    state_nx = IDLE;
        endcase
    end

    // in_ready is gated by rst so it reads 0 for the whole reset pulse.
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            i           <= '0;
            j           <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int f = 0; f < N_IN; f++)  x_q[f] <= '0;
            for (int h = 0; h < N_HID; h++) h_q[h] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int f = 0; f < N_IN; f++)
                            x_q[f] <= bus.in_data[f*IN_W +: IN_W];
                        acc <= MAC_W'(b1_tab[0]);
                        i   <= '0;
                        j   <= '0;
                    end
                end
                L0: begin
                    if (i == I_LAST) begin
                        // Last feature of this neuron: fold the final product straight into ReLU.
                        h_q[j] <= hid_act;
                        i      <= '0;
                        if (j == J_LAST) begin
                            acc <= MAC_W'(B2);
                            j   <= '0;
                        end else begin
                            acc <= MAC_W'(b1_tab[j + 1'b1]);
                            j   <= j + 1'b1;
                        end
                    end else begin
                        acc <= mac_sum;
                        i   <= i + 1'b1;
                    end
                end
                L1: begin
                    acc <= mac_sum;
                    if (j == J_LAST)
                        out_q <= out_act;
                    else
                        j <= j + 1'b1;
                end
                DONE: begin
                    // First DONE cycle lets the result sit in out_q before it is offered.
                    if (!out_valid_q)
                        out_valid_q <= 1'b1;
                    else if (bus.out_ready)
                        out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_seq_regressor.sv
// Bench for mlp_seq_regressor: two small-config instances (truncating and
// saturating ReLU) run in lockstep on shared stimulus, plus a default 21x3
// instance driven with random feature vectors against an integer model.
module tb_mlp_seq_regressor;

    // Small config: W1 = {{3,-2},{1,1}}, B1 = {5,-20}, W2 = {2,4}, B2 = 7
    localparam logic [31:0]        S_W1 = 32'h0101FE03;
    localparam logic [23:0]        S_B1 = 24'hFEC005;
    localparam logic [15:0]        S_W2 = 16'h0402;
    localparam logic signed [16:0] S_B2 = 17'sd7;

    // Default config coefficients: W1 pattern, B1 = {-2000,-500,1000}, W2 = {37,-60,90}, B2 = -1234
    function automatic logic [503:0] mk_w1();
        logic [503:0] r;
        r = '0;
        for (int k = 0; k < 63; k++) r[k*8 +: 8] = 8'(k*73 + 19);
        return r;
    endfunction
    localparam logic [503:0]       D_W1 = mk_w1();
    localparam logic [35:0]        D_B1 = 36'h3E8E0C830;
    localparam logic [23:0]        D_W2 = 24'h5AC425;
    localparam logic signed [16:0] D_B2 = 17'h1FB2E;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int s_w1q[$] = '{3, -2, 1, 1};
    int s_b1q[$] = '{5, -20};
    int s_w2q[$] = '{2, 4};
    int d_w1q[$], d_b1q[$], d_w2q[$];
    int d_b2;

    mlp_seq_regressor_if #(.N_IN(2),  .IN_W(4), .OUT_W(22)) if_s ();
    mlp_seq_regressor_if #(.N_IN(2),  .IN_W(4), .OUT_W(22)) if_t ();
    mlp_seq_regressor_if #(.N_IN(21), .IN_W(4), .OUT_W(22)) if_d ();

    assign if_t.in_valid  = if_s.in_valid;
    assign if_t.in_data   = if_s.in_data;
    assign if_t.out_ready = if_s.out_ready;

    mlp_seq_regressor #(.N_IN(2), .N_HID(2), .HID_W(4), .RELU_SAT(1'b0),
        .W1(S_W1), .B1(S_B1), .W2(S_W2), .B2(S_B2)) dut_s (.clk(clk), .rst(rst), .bus(if_s));
    mlp_seq_regressor #(.N_IN(2), .N_HID(2), .HID_W(4), .RELU_SAT(1'b1),
        .W1(S_W1), .B1(S_B1), .W2(S_W2), .B2(S_B2)) dut_t (.clk(clk), .rst(rst), .bus(if_t));
    mlp_seq_regressor #(.W1(D_W1), .B1(D_B1), .W2(D_W2), .B2(D_B2))
        dut_d (.clk(clk), .rst(rst), .bus(if_d));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint wrap_m(input longint v, input int w);
        longint m, r;
        m = longint'(1) <<< w;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m/2) r -= m;
        return r;
    endfunction

    function automatic longint relu_m(input longint v, input int w, input bit sat);
        longint lim;
        lim = (longint'(1) <<< w) - 1;
        if (v < 0) return 0;
        if (sat) return (v > lim) ? lim : v;
        return v % (lim + 1);
    endfunction

    function automatic longint model(input int nin, input int nhid, input int acc_w,
                                     input int hid_w, input int out_w, input bit sat,
                                     input int x[$], input int w1[$], input int b1[$],
                                     input int w2[$], input int b2);
        longint h[$];
        longint a;
        for (int jj = 0; jj < nhid; jj++) begin
            a = b1[jj];
            for (int ii = 0; ii < nin; ii++) a += longint'(x[ii]) * w1[jj*nin + ii];
            h.push_back(relu_m(wrap_m(a, acc_w), hid_w, sat));
        end
        a = b2;
        for (int jj = 0; jj < nhid; jj++) a += h[jj] * w2[jj];
        return relu_m(wrap_m(a, out_w), out_w - 1, sat);
    endfunction

    // Present (x0,x1) to the small pair, accept, then wait for out_valid (handshake left to caller).
    task automatic s_start(input int x0, input int x1, output int lat);
        int n;
        n = 0;
        if_s.in_data  = {4'(x1), 4'(x0)};
        if_s.in_valid = 1'b1;
        while (!if_s.in_ready && n < 100) begin tick(); n++; end
        chk("s_accept_ready", 64'(if_s.in_ready), 1);
        tick();
        if_s.in_valid = 1'b0;
        lat = 0;
        while (!if_s.out_valid && lat < 100) begin tick(); lat++; end
    endtask

    task automatic d_run(input logic [83:0] din, output logic [63:0] res, output int lat);
        int n;
        n = 0;
        if_d.in_data  = din;
        if_d.in_valid = 1'b1;
        while (!if_d.in_ready && n < 200) begin tick(); n++; end
        tick();
        if_d.in_valid = 1'b0;
        lat = 0;
        while (!if_d.out_valid && lat < 200) begin tick(); lat++; end
        res = 64'(if_d.out_data);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int xq[$];
        logic [63:0] res, held;
        logic [83:0] din;
        bit flag, flag2;
        int x0, x1, v;

        for (int k = 0; k < 63; k++) d_w1q.push_back(int'($signed(D_W1[k*8 +: 8])));
        for (int k = 0; k < 3; k++)  d_b1q.push_back(int'($signed(D_B1[k*12 +: 12])));
        for (int k = 0; k < 3; k++)  d_w2q.push_back(int'($signed(D_W2[k*8 +: 8])));
        d_b2 = int'(D_B2);

        rst = 1'b1;
        if_s.in_valid = 1'b0; if_s.in_data = '0; if_s.out_ready = 1'b1;
        if_d.in_valid = 1'b0; if_d.in_data = '0; if_d.out_ready = 1'b1;

        // Reset state
        tick();
        chk("rst_in_ready",  64'(if_s.in_ready), 0);
        chk("rst_out_valid", 64'(if_s.out_valid), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(if_s.in_ready), 1);
        chk("post_rst_out_data", 64'(if_s.out_data), 0);
        chk("post_rst_d_ready",  64'(if_d.in_ready), 1);

        // 1: x=(4,1) -> 37, latency 7
        s_start(4, 1, lat);
        chk("t1_latency", 64'(lat), 7);
        chk("t1_out_trunc", 64'(if_s.out_data), 37);
        chk("t1_out_sat",   64'(if_t.out_data), 37);
        chk("t1_valid_sat", 64'(if_t.out_valid), 1);
        tick();
        chk("t1_valid_drop", 64'(if_s.out_valid), 0);

        // 2: x=(5,0): truncation wraps h0 to 4, saturation clamps to 15
        s_start(5, 0, lat);
        chk("t2_out_trunc", 64'(if_s.out_data), 15);
        chk("t2_out_sat",   64'(if_t.out_data), 37);
        tick();

        // 3: consumer stalls 10 cycles; result held, new input refused
        if_s.out_ready = 1'b0;
        s_start(4, 1, lat);
        held = 64'(if_s.out_data);
        chk("t3_held_value", held, 37);
        flag = 1'b1; flag2 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if_s.in_valid = 1'b1;
            if_s.in_data  = {4'd9, 4'd9};
            tick();
            if (64'(if_s.out_data) !== held || if_s.out_valid !== 1'b1) flag = 1'b0;
            if (if_s.in_ready !== 1'b0) flag2 = 1'b0;
        end
        chk("t3_out_stable", 64'(flag), 1);
        chk("t3_in_blocked", 64'(flag2), 1);
        if_s.in_valid  = 1'b0;
        if_s.out_ready = 1'b1;
        tick();
        chk("t3_valid_drop", 64'(if_s.out_valid), 0);
        chk("t3_idle_ready", 64'(if_s.in_ready), 1);
        s_start(0, 0, lat);
        chk("t3_next_out", 64'(if_s.out_data), 17);
        tick();

        // 4: reset two cycles into L0
        if_s.in_data  = {4'd1, 4'd4};
        if_s.in_valid = 1'b1;
        chk("t4_ready", 64'(if_s.in_ready), 1);
        tick();
        if_s.in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t4_out_valid", 64'(if_s.out_valid), 0);
        chk("t4_in_ready",  64'(if_s.in_ready), 1);
        flag = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (if_s.out_valid !== 1'b0) flag = 1'b1;
        end
        chk("t4_no_partial", 64'(flag), 0);
        s_start(4, 1, lat);
        chk("t4_after_rst", 64'(if_s.out_data), 37);
        tick();

        // 5: back-to-back with in_valid held; data change while busy is ignored
        if_s.in_data  = {4'd1, 4'd4};
        if_s.in_valid = 1'b1;
        tick();
        if_s.in_data = {4'd0, 4'd0};
        lat = 0;
        while (!if_s.out_valid && lat < 100) begin tick(); lat++; end
        chk("t5_first_lat", 64'(lat), 7);
        chk("t5_first_out", 64'(if_s.out_data), 37);
        tick();
        chk("t5_ready_again", 64'(if_s.in_ready), 1);
        tick();
        if_s.in_valid = 1'b0;
        lat = 0;
        while (!if_s.out_valid && lat < 100) begin tick(); lat++; end
        chk("t5_second_lat", 64'(lat), 7);
        chk("t5_second_out", 64'(if_s.out_data), 17);
        tick();

        // Small config random vectors, both ReLU flavours
        for (int n = 0; n < 24; n++) begin
            x0 = int'($urandom_range(15, 0));
            x1 = int'($urandom_range(15, 0));
            xq = '{x0, x1};
            s_start(x0, x1, lat);
            chk("rnd_s_trunc", 64'(if_s.out_data),
                64'(model(2, 2, 14, 4, 22, 1'b0, xq, s_w1q, s_b1q, s_w2q, 7)));
            chk("rnd_s_sat", 64'(if_t.out_data),
                64'(model(2, 2, 14, 4, 22, 1'b1, xq, s_w1q, s_b1q, s_w2q, 7)));
            tick();
        end

        // 6: default 21x3 config, 200 random vectors
        for (int n = 0; n < 200; n++) begin
            xq.delete();
            din = '0;
            for (int f = 0; f < 21; f++) begin
                v = int'($urandom_range(15, 0));
                xq.push_back(v);
                din[f*4 +: 4] = 4'(v);
            end
            d_run(din, res, lat);
            chk("rnd_d_latency", 64'(lat), 67);
            chk("rnd_d_out", res,
                64'(model(21, 3, 14, 13, 22, 1'b0, xq, d_w1q, d_b1q, d_w2q, d_b2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
